ram_sync_be: RTL and testbench

//  Parametrised single-port synchronous RAM: successor to the 8-bit-address/32-bit RAM.

---
 rtl/ram_sync_be_if.sv | 33 +++
 rtl/ram_sync_be.sv | 165 ++++++++++++++++
 tb/tb_ram_sync_be.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_sync_be_if.sv
// ============================================================================
// ram_sync_be_if : request/response bus for the byte-enable synchronous RAM
// Rev 1.0
// ============================================================================
`default_nettype none

interface ram_sync_be_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  busy;
  logic                  err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, busy, err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/ram_sync_be.sv
// ============================================================================
// ram_sync_be : single-port synchronous RAM, byte enables, clear-after-reset
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_sync_be #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 256,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  wire             clk,
  input  wire             rst_n,
  ram_sync_be_if.slave    io_bus
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   C_DEPTH    = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_CLEAR = 2'd1,
    S_READY = 2'd2
  } state_t;

  // With clearing disabled, S_INIT gives one not-ready cycle after release.
  localparam state_t C_RST_STATE = (CLEAR_ON_RST != 0) ? S_CLEAR : S_INIT;

  state_t               r_state;
  state_t               w_next;
  logic                 w_ready;
  logic                 w_busy;
  logic                 w_clr_we;
  logic [IDX_W-1:0]     r_clr_cnt;

  logic [DATA_W-1:0]    r_mem [DEPTH];

  logic                 w_in_range;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_accept;
  logic                 w_rd_acc;
  logic                 w_wr_acc;
  logic [DATA_W-1:0]    w_rd_word;

  logic                 r_p1_valid;
  logic [DATA_W-1:0]    r_p1_data;
  logic                 r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_RST_STATE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_ready  = 1'b0;
    w_busy   = 1'b0;
    w_clr_we = 1'b0;
    case (r_state)
      S_INIT: begin
        w_next = S_READY;
      end
      S_CLEAR: begin
        w_busy   = 1'b1;
        w_clr_we = 1'b1;
        if (r_clr_cnt == C_LAST_IDX) begin
          w_next = S_READY;
        end
      end
      S_READY: begin
        w_ready = 1'b1;
      end
      default: begin
        w_next = C_RST_STATE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_cnt <= '0;
    end else if (w_clr_we) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  // Full-width compare so an address at or beyond DEPTH never aliases.
  assign w_in_range = ({1'b0, io_bus.req_addr} < C_DEPTH);
  assign w_idx      = io_bus.req_addr[IDX_W-1:0];
  assign w_accept   = io_bus.req_valid & w_ready;
  assign w_rd_acc   = w_accept & ~io_bus.req_we;
  assign w_wr_acc   = w_accept & io_bus.req_we & w_in_range;

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (io_bus.req_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= io_bus.req_wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    w_rd_word = '0;
    if (w_in_range) begin
      w_rd_word = r_mem[w_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_valid <= 1'b0;
      r_p1_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_p1_valid <= w_rd_acc;
      r_err      <= w_accept & ~w_in_range;
      if (w_rd_acc) begin
        r_p1_data <= w_rd_word;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              r_p2_valid;
      logic [DATA_W-1:0] r_p2_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_p2_valid <= 1'b0;
          r_p2_data  <= '0;
        end else begin
          r_p2_valid <= r_p1_valid;
          if (r_p1_valid) begin
            r_p2_data <= r_p1_data;
          end
        end
      end

      assign io_bus.rsp_valid = r_p2_valid;
      assign io_bus.rsp_rdata = r_p2_data;
    end else begin : g_lat1
      assign io_bus.rsp_valid = r_p1_valid;
      assign io_bus.rsp_rdata = r_p1_data;
    end
  endgenerate

  assign io_bus.req_ready = w_ready;
  assign io_bus.busy      = w_busy;
  assign io_bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ram_sync_be.sv
// ============================================================================
// tb_ram_sync_be : directed self-checking bench for ram_sync_be
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ram_sync_be;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        t_valid = 1'b0;
  logic [1:0]  t_sel   = 2'd0;
  logic        t_we    = 1'b0;
  logic [7:0]  t_addr  = '0;
  logic [31:0] t_wdata = '0;
  logic [3:0]  t_be    = '0;

  int checks = 0;
  int errors = 0;

  // a: 256/lat1, b: 256/lat2, c: 200/lat1, d: 16/lat1/no clear
  ram_sync_be_if #(.DATA_W(32), .ADDR_W(8)) if_a ();
  ram_sync_be_if #(.DATA_W(32), .ADDR_W(8)) if_b ();
  ram_sync_be_if #(.DATA_W(32), .ADDR_W(8)) if_c ();
  ram_sync_be_if #(.DATA_W(32), .ADDR_W(8)) if_d ();

  assign if_a.req_valid = t_valid && (t_sel == 2'd0);
  assign if_b.req_valid = t_valid && (t_sel == 2'd1);
  assign if_c.req_valid = t_valid && (t_sel == 2'd2);
  assign if_d.req_valid = t_valid && (t_sel == 2'd3);
  assign if_a.req_we = t_we;  assign if_a.req_addr = t_addr;
  assign if_a.req_wdata = t_wdata;  assign if_a.req_be = t_be;
  assign if_b.req_we = t_we;  assign if_b.req_addr = t_addr;
  assign if_b.req_wdata = t_wdata;  assign if_b.req_be = t_be;
  assign if_c.req_we = t_we;  assign if_c.req_addr = t_addr;
  assign if_c.req_wdata = t_wdata;  assign if_c.req_be = t_be;
  assign if_d.req_we = t_we;  assign if_d.req_addr = t_addr;
  assign if_d.req_wdata = t_wdata;  assign if_d.req_be = t_be;

  ram_sync_be #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .RD_LAT(1), .CLEAR_ON_RST(1))
    u_a (.clk(clk), .rst_n(rst_n), .io_bus(if_a.slave));
  ram_sync_be #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .RD_LAT(2), .CLEAR_ON_RST(1))
    u_b (.clk(clk), .rst_n(rst_n), .io_bus(if_b.slave));
  ram_sync_be #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .RD_LAT(1), .CLEAR_ON_RST(1))
    u_c (.clk(clk), .rst_n(rst_n), .io_bus(if_c.slave));
  ram_sync_be #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .RD_LAT(1), .CLEAR_ON_RST(0))
    u_d (.clk(clk), .rst_n(rst_n), .io_bus(if_d.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] sel, input logic we, input logic [7:0] addr,
                     input logic [31:0] wd, input logic [3:0] be);
    t_sel = sel; t_we = we; t_addr = addr; t_wdata = wd; t_be = be; t_valid = 1'b1;
  endtask

  task automatic idle();
    t_valid = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int n, na, nb, nc;
  logic stray;

  initial begin
    repeat (3) tick();
    check("rst_ready",  {31'd0, if_a.req_ready}, 32'd0);
    check("rst_rvalid", {31'd0, if_a.rsp_valid}, 32'd0);
    check("rst_rdata",  if_a.rsp_rdata, 32'd0);
    check("rst_err",    {31'd0, if_a.err}, 32'd0);
    check("rst_busy_a", {31'd0, if_a.busy}, 32'd1);
    check("rst_busy_d", {31'd0, if_d.busy}, 32'd0);
    check("rst_ready_d", {31'd0, if_d.req_ready}, 32'd0);

    // Test 1: clear duration per configuration
    rst_n = 1'b1;
    n = 0; na = 0; nb = 0; nc = 0;
    while ((if_a.busy || if_b.busy || if_c.busy) && n < 400) begin
      na += int'(if_a.busy); nb += int'(if_b.busy); nc += int'(if_c.busy);
      n++;
      tick();
      if (n == 1) check("d_ready_first_edge", {31'd0, if_d.req_ready}, 32'd1);
    end
    check("busy_cycles_a", 32'(na), 32'd256);
    check("busy_cycles_b", 32'(nb), 32'd256);
    check("busy_cycles_c", 32'(nc), 32'd200);
    check("ready_after_clear", {31'd0, if_a.req_ready}, 32'd1);

    req(0, 0, 8'd255, 0, 4'hF); tick(); idle();
    check("rd255_valid", {31'd0, if_a.rsp_valid}, 32'd1);
    check("rd255_data",  if_a.rsp_rdata, 32'd0);
    check("rd255_err",   {31'd0, if_a.err}, 32'd0);

    // Test 2: back-to-back reads, RD_LAT=1
    req(0, 1, 8'd0, 32'd128, 4'hF); tick(); idle();
    check("wr_no_rsp", {31'd0, if_a.rsp_valid}, 32'd0);
    req(0, 1, 8'd4, 32'd4096, 4'hF); tick();
    req(0, 0, 8'd0, 0, 4'hF); tick();
    check("b2b_v0", {31'd0, if_a.rsp_valid}, 32'd1);
    check("b2b_d0", if_a.rsp_rdata, 32'd128);
    req(0, 0, 8'd4, 0, 4'hF); tick(); idle();
    check("b2b_v1", {31'd0, if_a.rsp_valid}, 32'd1);
    check("b2b_d1", if_a.rsp_rdata, 32'd4096);
    tick();
    check("b2b_v2", {31'd0, if_a.rsp_valid}, 32'd0);
    check("rdata_hold", if_a.rsp_rdata, 32'd4096);

    // Test 3: byte-enable merge, then a be=0 no-op write
    req(0, 1, 8'd8, 32'hAABBCCDD, 4'hF); tick();
    req(0, 1, 8'd8, 32'h11223344, 4'b0101); tick();
    req(0, 1, 8'd8, 32'h0, 4'b0000); tick();
    req(0, 0, 8'd8, 0, 4'hF); tick(); idle();
    check("be_merge", if_a.rsp_rdata, 32'hAA22CC44);

    // Test 4: read-after-write, both latencies
    req(0, 1, 8'd3, 32'h5, 4'hF); tick();
    req(0, 0, 8'd3, 0, 4'hF); tick(); idle();
    check("raw_lat1", if_a.rsp_rdata, 32'h5);
    req(1, 1, 8'd3, 32'h5, 4'hF); tick();
    req(1, 1, 8'd9, 32'h7, 4'hF); tick();
    req(1, 0, 8'd3, 0, 4'hF); tick();
    check("lat2_t1_valid", {31'd0, if_b.rsp_valid}, 32'd0);
    req(1, 0, 8'd9, 0, 4'hF); tick(); idle();
    check("lat2_t2_valid", {31'd0, if_b.rsp_valid}, 32'd1);
    check("lat2_t2_data", if_b.rsp_rdata, 32'h5);
    tick();
    check("lat2_b2b_valid", {31'd0, if_b.rsp_valid}, 32'd1);
    check("lat2_b2b_data", if_b.rsp_rdata, 32'h7);
    tick();
    check("lat2_done", {31'd0, if_b.rsp_valid}, 32'd0);

    // Test 5: DEPTH=200 boundaries
    req(2, 1, 8'd199, 32'hABCD, 4'hF); tick();
    check("c199_wr_err", {31'd0, if_c.err}, 32'd0);
    req(2, 0, 8'd199, 0, 4'hF); tick();
    check("c199_data", if_c.rsp_rdata, 32'hABCD);
    req(2, 1, 8'd200, 32'hFFFF, 4'hF); tick(); idle();
    check("c200_wr_err", {31'd0, if_c.err}, 32'd1);
    check("c200_wr_norsp", {31'd0, if_c.rsp_valid}, 32'd0);
    tick();
    check("c200_err_pulse", {31'd0, if_c.err}, 32'd0);
    req(2, 0, 8'd200, 0, 4'hF); tick(); idle();
    check("c200_rd_valid", {31'd0, if_c.rsp_valid}, 32'd1);
    check("c200_rd_data", if_c.rsp_rdata, 32'd0);
    check("c200_rd_err", {31'd0, if_c.err}, 32'd1);
    req(2, 0, 8'd199, 0, 4'hF); tick(); idle();
    check("c199_unchanged", if_c.rsp_rdata, 32'hABCD);

    req(3, 1, 8'd5, 32'h12, 4'hF); tick();
    req(3, 0, 8'd5, 0, 4'hF); tick(); idle();
    check("d_rd", if_d.rsp_rdata, 32'h12);

    // Test 6: reset at a read's T+1, then mid-clear
    req(1, 0, 8'd3, 0, 4'hF); tick(); idle();
    rst_n = 1'b0;
    #1;
    check("rst_drop_v", {31'd0, if_b.rsp_valid}, 32'd0);
    check("rst_drop_d", if_b.rsp_rdata, 32'd0);
    tick();
    rst_n = 1'b1;
    n = 0; stray = 1'b0;
    while (if_a.busy && n < 100) begin
      stray |= if_a.rsp_valid | if_b.rsp_valid | if_c.rsp_valid;
      n++;
      tick();
    end
    check("mid_clear_reached", 32'(n), 32'd100);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n = 0;
    while ((if_a.busy || if_b.busy) && n < 400) begin
      stray |= if_a.rsp_valid | if_b.rsp_valid | if_c.rsp_valid;
      n++;
      tick();
    end
    check("restart_busy", 32'(n), 32'd256);
    check("no_stray_rsp", {31'd0, stray}, 32'd0);
    req(0, 0, 8'd8, 0, 4'hF); tick();
    check("recleared_8", if_a.rsp_rdata, 32'd0);
    req(0, 0, 8'd4, 0, 4'hF); tick(); idle();
    check("recleared_4", if_a.rsp_rdata, 32'd0);
    req(1, 0, 8'd9, 0, 4'hF); tick(); idle(); tick();
    check("recleared_b9", if_b.rsp_rdata, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
